dcache_sram_nway: RTL and testbench

Parametrised N-way set-associative data-cache storage array with true-LRU replacement, dirty tracking and an optional flush engine. It generalises the 2-way/16-set L1 dcache SRAM to configurable sets, ways and widths. It sits under the dcache controller: the controller issues lookups and fills, and it drains dirty lines to memory through a valid/ready write-back port during flush.

---
 rtl/dcache_sram_nway.sv | 204 ++++++++++++++++++++
 tb/tb_dcache_sram_nway.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_sram_nway.sv
// N-way set-associative dcache storage array with true-LRU replacement and dirty tracking.
// Defining DCACHE_SRAM_FLUSH_EN adds the flush engine and its valid/ready write-back port.
module dcache_sram_nway #(
    parameter int unsigned SETS   = 16,
    parameter int unsigned WAYS   = 4,
    parameter int unsigned TAG_W  = 23,
    parameter int unsigned LINE_W = 256,
    localparam int unsigned IDX_W = $clog2(SETS),
    localparam int unsigned AGE_W = $clog2(WAYS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [TAG_W+1:0]  tag_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic [TAG_W+1:0]  tag_o,
    output logic [LINE_W-1:0] data_o,
    output logic              hit_o,
    input  logic              flush_i,
    output logic              flush_busy_o,
    output logic              flush_done_o,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [IDX_W-1:0]  wb_addr_o,
    output logic [TAG_W-1:0]  wb_tag_o,
    output logic [LINE_W-1:0] wb_data_o
);

    logic              valid_q [SETS][WAYS];
    logic              dirty_q [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [LINE_W-1:0] data_q  [SETS][WAYS];
    logic [AGE_W-1:0]  age_q   [SETS][WAYS];

    logic             busy;
    logic             clr_dirty;
    logic [IDX_W-1:0] clr_set;
    logic [AGE_W-1:0] clr_way;

    logic             hit_any;
    logic             inv_found;
    logic [AGE_W-1:0] hit_way;
    logic [AGE_W-1:0] inv_way;
    logic [AGE_W-1:0] lru_way;
    logic [AGE_W-1:0] sel_way;
    logic             access;
    logic             do_write;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit_any   = 1'b0;
        inv_found = 1'b0;
        hit_way   = '0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[addr_i][w] && (tag_q[addr_i][w] == tag_i[TAG_W-1:0])) begin
                hit_any = 1'b1;
                hit_way = AGE_W'(w);
            end
            if (!valid_q[addr_i][w]) begin
                inv_found = 1'b1;
                inv_way   = AGE_W'(w);
            end
            if (age_q[addr_i][w] == AGE_W'(WAYS - 1)) begin
                lru_way = AGE_W'(w);
            end
        end
        sel_way = hit_any ? hit_way : (inv_found ? inv_way : lru_way);
    end

    assign access   = enable_i && !busy && (hit_any || write_i);
    assign do_write = enable_i && !busy && write_i;

    assign hit_o  = hit_any && !busy;
    assign tag_o  = {valid_q[addr_i][sel_way], dirty_q[addr_i][sel_way], tag_q[addr_i][sel_way]};
    assign data_o = data_q[addr_i][sel_way];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    data_q[s][w]  <= '0;
                    age_q[s][w]   <= AGE_W'(w);
                end
            end
        end else begin
            if (do_write) begin
                valid_q[addr_i][sel_way] <= tag_i[TAG_W+1];
                dirty_q[addr_i][sel_way] <= tag_i[TAG_W];
                tag_q[addr_i][sel_way]   <= tag_i[TAG_W-1:0];
                data_q[addr_i][sel_way]  <= data_i;
            end
            // Accessed way becomes youngest; only younger ways age, keeping a permutation.
            if (access) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AGE_W'(w) == sel_way) begin
                        age_q[addr_i][w] <= '0;
                    end else if (age_q[addr_i][w] < age_q[addr_i][sel_way]) begin
                        age_q[addr_i][w] <= age_q[addr_i][w] + AGE_W'(1);
                    end
                end
            end
            if (clr_dirty) begin
                dirty_q[clr_set][clr_way] <= 1'b0;
            end
        end
    end

`ifdef DCACHE_SRAM_FLUSH_EN
    typedef enum logic [1:0] {StIdle, StScan, StEmit, StDone} flush_state_e;

    flush_state_e             state_q, state_d;
    logic [IDX_W+AGE_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]         ptr_set;
    logic [AGE_W-1:0]         ptr_way;
    logic                     ptr_last;

    // Pointer is {set, way}, so a plain increment walks ways before sets.
    assign ptr_set  = ptr_q[IDX_W+AGE_W-1:AGE_W];
    assign ptr_way  = ptr_q[AGE_W-1:0];
    assign ptr_last = &ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        clr_dirty = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (flush_i) begin
                    state_d = StScan;
                    ptr_d   = '0;
                end
            end
            StScan: begin
                if (valid_q[ptr_set][ptr_way] && dirty_q[ptr_set][ptr_way]) begin
                    state_d = StEmit;
                end else if (ptr_last) begin
                    state_d = StDone;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            StEmit: begin
                if (wb_ready_i) begin
                    clr_dirty = 1'b1;
                    if (ptr_last) begin
                        state_d = StDone;
                    end else begin
                        state_d = StScan;
                        ptr_d   = ptr_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy         = (state_q != StIdle);
    assign flush_busy_o = busy;
    assign flush_done_o = (state_q == StDone);
    assign wb_valid_o   = (state_q == StEmit);
    assign wb_addr_o    = ptr_set;
    assign wb_tag_o     = tag_q[ptr_set][ptr_way];
    assign wb_data_o    = data_q[ptr_set][ptr_way];
    assign clr_set      = ptr_set;
    assign clr_way      = ptr_way;
`else
    logic unused_flush;
    assign unused_flush = ^{flush_i, wb_ready_i};

    assign busy         = 1'b0;
    assign clr_dirty    = 1'b0;
    assign clr_set      = '0;
    assign clr_way      = '0;
    assign flush_busy_o = 1'b0;
    assign flush_done_o = 1'b0;
    assign wb_valid_o   = 1'b0;
    assign wb_addr_o    = '0;
    assign wb_tag_o     = '0;
    assign wb_data_o    = '0;
`endif

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Self-checking bench for dcache_sram_nway: directed vector table, flush sequences and
// randomized traffic against an MRU-ordered list model of the cache.
module tb_dcache_sram_nway;

    localparam int SETS   = 16;
    localparam int WAYS   = 4;
    localparam int TAG_W  = 23;
    localparam int LINE_W = 256;
    localparam int IDX_W  = $clog2(SETS);
    localparam int AGE_W  = $clog2(WAYS);

    logic              clk = 1'b0;
    logic              rst_i;
    logic [IDX_W-1:0]  addr_i;
    logic [TAG_W+1:0]  tag_i;
    logic [LINE_W-1:0] data_i;
    logic              enable_i;
    logic              write_i;
    logic [TAG_W+1:0]  tag_o;
    logic [LINE_W-1:0] data_o;
    logic              hit_o;
    logic              flush_i;
    logic              flush_busy_o;
    logic              flush_done_o;
    logic              wb_valid_o;
    logic              wb_ready_i;
    logic [IDX_W-1:0]  wb_addr_o;
    logic [TAG_W-1:0]  wb_tag_o;
    logic [LINE_W-1:0] wb_data_o;

    dcache_sram_nway #(
        .SETS  (SETS),
        .WAYS  (WAYS),
        .TAG_W (TAG_W),
        .LINE_W(LINE_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .addr_i      (addr_i),
        .tag_i       (tag_i),
        .data_i      (data_i),
        .enable_i    (enable_i),
        .write_i     (write_i),
        .tag_o       (tag_o),
        .data_o      (data_o),
        .hit_o       (hit_o),
        .flush_i     (flush_i),
        .flush_busy_o(flush_busy_o),
        .flush_done_o(flush_done_o),
        .wb_valid_o  (wb_valid_o),
        .wb_ready_i  (wb_ready_i),
        .wb_addr_o   (wb_addr_o),
        .wb_tag_o    (wb_tag_o),
        .wb_data_o   (wb_data_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: per-set list of ways ordered most- to least-recently used.
    bit                m_valid [SETS][WAYS];
    bit                m_dirty [SETS][WAYS];
    logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
    logic [LINE_W-1:0] m_data  [SETS][WAYS];
    int                m_order [SETS][WAYS];

    typedef struct {
        bit               en;
        bit               wr;
        int               addr;
        logic [TAG_W+1:0] tag;
        bit               exp_hit;
        logic [TAG_W+1:0] exp_tag;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void m_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_tag[s][w]   = '0;
                m_data[s][w]  = '0;
                m_order[s][w] = w;
            end
        end
    endfunction

    function automatic void m_select(input int s, input logic [TAG_W-1:0] t,
                                     output bit hit, output int way);
        hit = 1'b0;
        way = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) begin
                hit = 1'b1;
                way = w;
                break;
            end
        end
        if (!hit) begin
            for (int w = 0; w < WAYS; w++) begin
                if (!m_valid[s][w]) begin
                    way = w;
                    break;
                end
            end
            if (way < 0) way = m_order[s][WAYS-1];
        end
    endfunction

    function automatic void m_touch(input int s, input int way);
        int pos = 0;
        for (int i = 0; i < WAYS; i++) if (m_order[s][i] == way) pos = i;
        for (int i = pos; i > 0; i--) m_order[s][i] = m_order[s][i-1];
        m_order[s][0] = way;
    endfunction

    function automatic logic [LINE_W-1:0] rnd_line();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic vec_t mk(input bit en, input bit wr, input int addr, input bit v,
                                input bit d, input int t, input bit eh, input bit ev,
                                input bit ed, input int et);
        vec_t r;
        r.en      = en;
        r.wr      = wr;
        r.addr    = addr;
        r.tag     = {v, d, TAG_W'(t)};
        r.exp_hit = eh;
        r.exp_tag = {ev, ed, TAG_W'(et)};
        return r;
    endfunction

    // One access cycle; called and returns at posedge+1.
    task automatic op(input bit en, input bit wr, input int s, input logic [TAG_W+1:0] t,
                      input logic [LINE_W-1:0] d, input bit use_exp, input bit exp_hit,
                      input logic [TAG_W+1:0] exp_tag, input string nm);
        bit hit;
        int way;
        enable_i = en;
        write_i  = wr;
        addr_i   = IDX_W'(s);
        tag_i    = t;
        data_i   = d;
        @(negedge clk);
        m_select(s, t[TAG_W-1:0], hit, way);
        if (use_exp) begin
            chk({nm, " hit"}, LINE_W'(hit_o), LINE_W'(exp_hit));
            chk({nm, " tag"}, LINE_W'(tag_o), LINE_W'(exp_tag));
        end else begin
            chk({nm, " hit"}, LINE_W'(hit_o), LINE_W'(hit));
            chk({nm, " tag"}, LINE_W'(tag_o),
                LINE_W'({m_valid[s][way], m_dirty[s][way], m_tag[s][way]}));
        end
        chk({nm, " data"}, data_o, m_data[s][way]);
        @(posedge clk);
        #1;
        if (en && wr) begin
            m_valid[s][way] = t[TAG_W+1];
            m_dirty[s][way] = t[TAG_W];
            m_tag[s][way]   = t[TAG_W-1:0];
            m_data[s][way]  = d;
        end
        if (en && (hit || wr)) m_touch(s, way);
        enable_i = 1'b0;
        write_i  = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        m_reset();
    endtask

    task automatic rand_ops(input int n);
        bit               en;
        bit               wr;
        int               s;
        logic [TAG_W+1:0] t;
        for (int i = 0; i < n; i++) begin
            en = ($urandom_range(0, 9) < 8);
            wr = ($urandom_range(0, 9) < 4);
            s  = $urandom_range(0, 3);
            t  = {($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                  TAG_W'($urandom_range(0, 5))};
            op(en, wr, s, t, rnd_line(), 1'b0, 1'b0, '0, "rand");
        end
    endtask

`ifdef DCACHE_SRAM_FLUSH_EN
    // Walks the model in scan order; expected timing follows from which lines are dirty.
    task automatic flush_run(input int first_wait, input int poke_e);
        int emitted = 0;
        int s;
        int w;
        int waits;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        for (int e = 0; e < SETS * WAYS; e++) begin
            s = e / WAYS;
            w = e % WAYS;
            if (e == poke_e) begin
                enable_i = 1'b1;
                write_i  = 1'b1;
                addr_i   = IDX_W'(1);
                tag_i    = {2'b11, TAG_W'('h31)};
                data_i   = '1;
            end
            @(negedge clk);
            chk("scan busy/wb_valid/done", LINE_W'({flush_busy_o, wb_valid_o, flush_done_o}),
                LINE_W'(3'b100));
            if (e == poke_e) chk("hit masked during flush", LINE_W'(hit_o), '0);
            @(posedge clk);
            #1;
            enable_i = 1'b0;
            write_i  = 1'b0;
            if (m_valid[s][w] && m_dirty[s][w]) begin
                waits = (emitted == 0) ? first_wait : 0;
                for (int k = 0; k <= waits; k++) begin
                    wb_ready_i = (k == waits);
                    @(negedge clk);
                    chk("emit busy/wb_valid/done",
                        LINE_W'({flush_busy_o, wb_valid_o, flush_done_o}), LINE_W'(3'b110));
                    chk("wb_addr", LINE_W'(wb_addr_o), LINE_W'(s));
                    chk("wb_tag", LINE_W'(wb_tag_o), LINE_W'(m_tag[s][w]));
                    chk("wb_data", wb_data_o, m_data[s][w]);
                    @(posedge clk);
                    #1;
                end
                wb_ready_i    = 1'b0;
                m_dirty[s][w] = 1'b0;
                emitted++;
            end
        end
        @(negedge clk);
        chk("done pulse", LINE_W'({flush_busy_o, wb_valid_o, flush_done_o}), LINE_W'(3'b101));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("idle after flush", LINE_W'({flush_busy_o, wb_valid_o, flush_done_o}), '0);
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(1, 0, 3, 0, 0, 'h12, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) vecs[1+i] = mk(1, 1, 3, 1, 0, 'h10 + i, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) vecs[5+i] = mk(1, 0, 3, 0, 0, 'h10 + i, 1, 1, 0, 'h10 + i);
        vecs[9]  = mk(1, 0, 3, 0, 0, 'h55, 0, 1, 0, 'h10);
        for (int i = 0; i < 4; i++) vecs[10+i] = mk(1, 1, 5, 1, 0, 'hA0 + i, 0, 0, 0, 0);
        vecs[14] = mk(1, 0, 5, 0, 0, 'hA0, 1, 1, 0, 'hA0);
        vecs[15] = mk(1, 0, 5, 0, 0, 'hE0, 0, 1, 0, 'hA1);
        vecs[16] = mk(1, 1, 5, 1, 0, 'hE0, 0, 1, 0, 'hA1);
        vecs[17] = mk(1, 0, 5, 0, 0, 'hE0, 1, 1, 0, 'hE0);
        vecs[18] = mk(1, 0, 5, 0, 0, 'h77, 0, 1, 0, 'hA2);
        vecs[19] = mk(1, 1, 2, 1, 0, 'h20, 0, 0, 0, 0);
        vecs[20] = mk(1, 1, 2, 1, 1, 'h20, 1, 1, 0, 'h20);
        vecs[21] = mk(1, 0, 2, 0, 0, 'h20, 1, 1, 1, 'h20);

        rst_i      = 1'b1;
        addr_i     = '0;
        tag_i      = '0;
        data_i     = '0;
        enable_i   = 1'b0;
        write_i    = 1'b0;
        flush_i    = 1'b0;
        wb_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        m_reset();

        @(negedge clk);
        chk("reset hit", LINE_W'(hit_o), '0);
        chk("reset tag", LINE_W'(tag_o), '0);
        chk("reset data", data_o, '0);
        chk("reset busy/wb_valid/done", LINE_W'({flush_busy_o, wb_valid_o, flush_done_o}), '0);
        @(posedge clk);
        #1;

`ifdef DCACHE_SRAM_FLUSH_EN
        flush_run(0, -1);
`endif

        for (int i = 0; i < 22; i++) begin
            op(vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].tag,
               {8{32'hC0DE_0000 + 32'(i)}}, 1'b1, vecs[i].exp_hit, vecs[i].exp_tag,
               $sformatf("vec%0d", i));
        end

        rand_ops(300);

`ifdef DCACHE_SRAM_FLUSH_EN
        flush_run(2, -1);
        rand_ops(60);

        do_reset();
        op(1, 1, 1, {2'b10, TAG_W'('h31)}, rnd_line(), 1'b0, 1'b0, '0, "fill");
        op(1, 1, 1, {2'b10, TAG_W'('h32)}, rnd_line(), 1'b0, 1'b0, '0, "fill");
        op(1, 1, 1, {2'b11, TAG_W'('h30)}, rnd_line(), 1'b0, 1'b0, '0, "fill");
        op(1, 1, 9, {2'b11, TAG_W'('h40)}, rnd_line(), 1'b0, 1'b0, '0, "fill");
        op(1, 1, 4, {2'b10, TAG_W'('h50)}, rnd_line(), 1'b0, 1'b0, '0, "fill");
        flush_run(3, 2);
        op(1, 0, 1, {2'b00, TAG_W'('h30)}, '0, 1'b1, 1'b1, {2'b10, TAG_W'('h30)}, "post1");
        op(1, 0, 9, {2'b00, TAG_W'('h40)}, '0, 1'b1, 1'b1, {2'b10, TAG_W'('h40)}, "post9");
        op(1, 0, 1, {2'b00, TAG_W'('h31)}, '0, 1'b1, 1'b1, {2'b10, TAG_W'('h31)}, "post1b");

        // Reset while a line is being presented.
        do_reset();
        op(1, 1, 0, {2'b11, TAG_W'('h7)}, rnd_line(), 1'b0, 1'b0, '0, "fill0");
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("emit before reset", LINE_W'({wb_valid_o, wb_addr_o}), LINE_W'({1'b1, IDX_W'(0)}));
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        m_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("after abort busy/wb_valid/done",
                LINE_W'({flush_busy_o, wb_valid_o, flush_done_o}), '0);
            @(posedge clk);
            #1;
        end
        op(1, 0, 0, {2'b00, TAG_W'('h7)}, '0, 1'b1, 1'b0, '0, "miss after abort");
`else
        flush_i    = 1'b1;
        wb_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no flush busy/wb_valid/done",
                LINE_W'({flush_busy_o, wb_valid_o, flush_done_o}), '0);
            chk("no flush wb_addr/tag", LINE_W'({wb_addr_o, wb_tag_o}), '0);
            chk("no flush wb_data", wb_data_o, '0);
            @(posedge clk);
            #1;
        end
        flush_i    = 1'b0;
        wb_ready_i = 1'b0;
        rand_ops(60);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
